jtframe_db15_tx: RTL and testbench

- Device-side model of the DB15 joystick adapter: a serializer that answers the host's JOY_LOAD/JOY_CLK strobes by shifting two 16-bit joystick words out on JOY_DATA.
- It behaves as a 74HC165-style chain driven from the FPGA clock domain.
- Sits in simulation benches and loopback test cores, facing the DB15 reader in the MiSTer frame.
- Also used on a second board to emulate an adapter.

---
 rtl/jtframe_db15_tx.sv | 127 ++++++++++++
 tb/tb_jtframe_db15_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_db15_tx.sv
// Device-side DB15 joystick serializer: answers host JOY_LOAD/JOY_CLK strobes
// like a 74HC165 chain, shifting {~joystick1, ~joystick2} out MSB first.
module jtframe_db15_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 32
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        overrun,
  output logic [5:0]  bit_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] FULL_CNT = 6'(FRAME_BITS);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]  load_sync_q, load_sync_d;
  logic                    clk_prev_q, clk_prev_d;
  logic                    clk_rise_q, clk_rise_d;
  logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    ovr_q, ovr_d;
  logic                    load_active;
  logic [FRAME_BITS-1:0]   frame_word;
  logic [FRAME_BITS-1:0]   shifted;

  assign load_active = ~load_sync_q[SYNC_STAGES-1];
  assign frame_word  = {~joystick1, ~joystick2};
  assign shifted     = {sreg_q[FRAME_BITS-2:0], 1'b1};

  // The rise pulse is registered once more, so a host clock edge reaches
  // JOY_DATA one cycle later than a load does.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], JOY_CLK};
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], JOY_LOAD};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    clk_rise_d  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (load_active) begin
      // Transparent load: any pending shift this cycle is discarded.
      state_d = ST_LOADING;
      sreg_d  = frame_word;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clk_rise_q) sreg_d = shifted;
        end
        ST_LOADING: begin
          state_d = ST_SHIFTING;
        end
        ST_SHIFTING: begin
          if (clk_rise_q) begin
            sreg_d = shifted;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == LAST_CNT) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (clk_rise_q) begin
            sreg_d = shifted;
            ovr_d  = 1'b1;
            cnt_d  = FULL_CNT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clk_sync_q  <= '1;
      load_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      clk_rise_q  <= 1'b0;
      sreg_q      <= '1;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      load_sync_q <= load_sync_d;
      clk_prev_q  <= clk_prev_d;
      clk_rise_q  <= clk_rise_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign JOY_DATA   = sreg_q[FRAME_BITS-1];
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Bench for jtframe_db15_tx: two instances (2 and 3 sync stages) share the host
// lines and are checked against a frame-level model of what the host should read.
module tb_jtframe_db15_tx;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] joystick1 = 16'h0;
  logic [15:0] joystick2 = 16'h0;
  logic        JOY_CLK = 1'b0;
  logic        JOY_LOAD = 1'b1;

  logic       data_a, done_a, ovr_a;
  logic [5:0] cnt_a;
  logic [1:0] st_a;
  logic       data_b, done_b, ovr_b;
  logic [5:0] cnt_b;
  logic [1:0] st_b;

  jtframe_db15_tx #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(data_a), .frame_done(done_a),
    .overrun(ovr_a), .bit_cnt(cnt_a), .state_dbg(st_a)
  );

  jtframe_db15_tx #(.SYNC_STAGES(3), .FRAME_BITS(32)) dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(data_b), .frame_done(done_b),
    .overrun(ovr_b), .bit_cnt(cnt_b), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // frame_done pulse counters, sampled away from the active edge
  int pulses_a = 0;
  int pulses_b = 0;
  always @(negedge clk_sys) begin
    if (done_a) pulses_a++;
    if (done_b) pulses_b++;
  end

  // reference model: queue of bits the host should read next, plus counters
  logic [0:0] exp_q[$];
  int  rises_exp   = 0;
  bit  loaded_exp  = 1'b0;
  bit  ovr_exp     = 1'b0;
  int  pulses_exp  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [31:0] model_cnt();
    if (!loaded_exp) return 32'd0;
    return (rises_exp > 32) ? 32'd32 : 32'(rises_exp);
  endfunction

  // driver tasks
  task automatic model_load();
    logic [31:0] w;
    w = {~joystick1, ~joystick2};
    exp_q.delete();
    for (int i = 31; i >= 0; i--) exp_q.push_back(w[i]);
    rises_exp  = 0;
    loaded_exp = 1'b1;
  endtask

  task automatic do_load(input int low_cycles);
    JOY_LOAD = 1'b0;
    tick(low_cycles);
    JOY_LOAD = 1'b1;
    model_load();
    tick(6);
  endtask

  task automatic pulse_raw(input int hi, input int lo);
    JOY_CLK = 1'b1;
    tick(hi);
    JOY_CLK = 1'b0;
    tick(lo);
  endtask

  task automatic shift_bit(input int hi, input int lo);
    pulse_raw(hi, lo);
    if (loaded_exp) begin
      rises_exp++;
      if (rises_exp == 32) pulses_exp++;
      if (rises_exp > 32) ovr_exp = 1'b1;
    end
  endtask

  task automatic sample(input string tag, output logic bit_a);
    logic e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
    check({tag, "_data_a"}, 32'(data_a), 32'(e));
    check({tag, "_data_b"}, 32'(data_b), 32'(e));
    bit_a = data_a;
  endtask

  task automatic read_bits(input string tag, input int nrises, input int hi, input int lo,
                           output logic [31:0] word);
    logic b;
    word = '0;
    for (int i = 0; i < nrises; i++) begin
      sample(tag, b);
      if (i < 32) word[31-i] = b;
      shift_bit(hi, lo);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cnt_a"}, 32'(cnt_a), model_cnt());
    check({tag, "_cnt_b"}, 32'(cnt_b), model_cnt());
    check({tag, "_ovr_a"}, 32'(ovr_a), 32'(ovr_exp));
    check({tag, "_ovr_b"}, 32'(ovr_b), 32'(ovr_exp));
    check({tag, "_done_a"}, 32'(pulses_a), 32'(pulses_exp));
    check({tag, "_done_b"}, 32'(pulses_b), 32'(pulses_exp));
  endtask

  logic [31:0] word;
  logic        bt;
  int          lat_a, lat_b;

  initial begin
    // reset values while rst_n is low
    tick(3);
    check("rst_data_a", 32'(data_a), 32'd1);
    check("rst_data_b", 32'(data_b), 32'd1);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    rst_n = 1'b1;
    tick(4);
    check("idle_data", 32'(data_a), 32'd1);

    // basic frame
    joystick1 = 16'h0001;
    joystick2 = 16'h8000;
    do_load(4);
    read_bits("basic", 32, 8, 8, word);
    check("basic_word", word, 32'hFFFE_7FFF);
    check("basic_cnt", 32'(cnt_a), 32'd32);
    check_status("basic");

    // overrun: extra rises shift out ones and set the sticky flag
    read_bits("ovr", 3, 8, 8, word);
    sample("ovr_tail", bt);
    check("ovr_flag", 32'(ovr_a), 32'd1);
    check_status("ovr");

    // load priority over JOY_CLK
    joystick1 = 16'hA5A5;
    JOY_LOAD = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) pulse_raw(8, 8);
    check("prio_cnt_a", 32'(cnt_a), 32'd0);
    check("prio_cnt_b", 32'(cnt_b), 32'd0);
    JOY_LOAD = 1'b1;
    model_load();
    tick(6);
    read_bits("prio", 2, 8, 8, word);
    check("prio_first2", 32'(word[31:30]), 32'd1);
    check_status("prio");

    // mid-frame abort and reload
    read_bits("abort_pre", 8, 8, 8, word);
    joystick1 = 16'hFFFF;
    joystick2 = 16'h0000;
    JOY_LOAD = 1'b0;
    tick(4);
    check("abort_cnt_a", 32'(cnt_a), 32'd0);
    check("abort_cnt_b", 32'(cnt_b), 32'd0);
    JOY_LOAD = 1'b1;
    model_load();
    tick(6);
    read_bits("abort", 32, 8, 8, word);
    check("abort_word", word, 32'h0000_FFFF);
    check_status("abort");

    // reset mid-frame
    joystick1 = 16'h1234;
    joystick2 = 16'hFEDC;
    do_load(4);
    read_bits("rstmid", 7, 8, 8, word);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_q.delete();
    loaded_exp = 1'b0;
    ovr_exp    = 1'b0;
    rises_exp  = 0;
    check("rstmid_data_a", 32'(data_a), 32'd1);
    check("rstmid_data_b", 32'(data_b), 32'd1);
    check("rstmid_cnt", 32'(cnt_a), 32'd0);
    check("rstmid_ovr", 32'(ovr_a), 32'd0);
    tick(4);
    read_bits("rstmid_idle", 4, 8, 8, word);
    sample("rstmid_idle_end", bt);
    check_status("rstmid");

    // randomized frames with mid-frame joystick changes
    for (int it = 0; it < 20; it++) begin
      int n, hi, lo;
      joystick1 = 16'($urandom);
      joystick2 = 16'($urandom);
      do_load($urandom_range(3, 8));
      joystick1 = 16'($urandom);
      joystick2 = 16'($urandom);
      n  = $urandom_range(0, 36);
      hi = $urandom_range(6, 10);
      lo = $urandom_range(6, 10);
      read_bits("rnd", n, hi, lo, word);
      sample("rnd_end", bt);
      check_status("rnd");
    end

    // latency from an idle, freshly reset state
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    joystick1 = 16'h8000;
    joystick2 = 16'h0000;
    lat_a = -1;
    lat_b = -1;
    JOY_LOAD = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (lat_a < 0 && data_a == 1'b0) lat_a = c;
      if (lat_b < 0 && data_b == 1'b0) lat_b = c;
    end
    check("lat_load_a", 32'(lat_a), 32'd3);
    check("lat_load_b", 32'(lat_b), 32'd4);
    JOY_LOAD = 1'b1;
    tick(8);
    lat_a = -1;
    lat_b = -1;
    JOY_CLK = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (lat_a < 0 && data_a == 1'b1) lat_a = c;
      if (lat_b < 0 && data_b == 1'b1) lat_b = c;
    end
    JOY_CLK = 1'b0;
    check("lat_clk_a", 32'(lat_a), 32'd4);
    check("lat_clk_b", 32'(lat_b), 32'd5);
    tick(4);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
